// File: rtl/pmu_window_seq.sv
// -----------------------------------------------------------------------------
// pmu_window_seq
//
// Measurement-window sequencer for the PMU. Each window it pulses the PMU soft
// reset for one cycle (CLEAR), enables the counters for exactly the programmed
// number of cycles (RUN), then freezes them for one cycle (HOLD). It also
// raises a sticky interrupt so software can read a consistent snapshot.
//
// Optional feature: define PMU_WINDOW_SEQ_PERIODIC_EN to let periodic_i
// restart windows back-to-back. When the macro is undefined, periodic_i is
// ignored and HOLD always returns to IDLE.
//
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   start_i      start request, honoured in IDLE only
//   stop_i       abort request, returns to IDLE next cycle
//   window_i     window length in cycles, latched on an accepted start
//   periodic_i   auto-restart after each window (macro-dependent)
//   intr_clr_i   clears intr_o (a simultaneous set wins)
//   cfg_o        PMU config word: bit0 = enable, bit1 = soft reset
//   busy_o       high in CLEAR, RUN and HOLD
//   done_o       one-cycle pulse on entry to HOLD
//   intr_o       sticky window-complete interrupt
//   remaining_o  cycles left in the current window
//   windows_o    completed-window count, wraps
// -----------------------------------------------------------------------------
module pmu_window_seq #(
  parameter int REG_WIDTH = 32,
  parameter int WIN_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [WIN_WIDTH-1:0] window_i,
  input  logic                 periodic_i,
  input  logic                 intr_clr_i,
  output logic [REG_WIDTH-1:0] cfg_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 intr_o,
  output logic [WIN_WIDTH-1:0] remaining_o,
  output logic [CNT_WIDTH-1:0] windows_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [REG_WIDTH-1:0] CFG_OFF     = {REG_WIDTH{1'b0}};
  localparam logic [REG_WIDTH-1:0] CFG_EN      = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CFG_SOFTRST = REG_WIDTH'(2);
  localparam logic [WIN_WIDTH-1:0] WIN_ZERO    = {WIN_WIDTH{1'b0}};
  localparam logic [WIN_WIDTH-1:0] WIN_ONE     = WIN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t                 state_r;
  state_t                 state_s;
  logic [WIN_WIDTH-1:0]   win_r;
  logic [WIN_WIDTH-1:0]   win_s;
  logic [WIN_WIDTH-1:0]   rem_s;
  logic [REG_WIDTH-1:0]   cfg_s;
  logic [CNT_WIDTH-1:0]   windows_s;
  logic                   busy_s;
  logic                   done_s;
  logic                   intr_s;
  logic                   intr_set_s;
  logic                   periodic_s;

`ifdef PMU_WINDOW_SEQ_PERIODIC_EN
  assign periodic_s = periodic_i;
`else
  // Restart is compiled out; the input is intentionally left unused.
  logic unused_periodic_s;
  assign unused_periodic_s = periodic_i;
  assign periodic_s        = 1'b0;
`endif

  // Next-state and next-output computation; every output is then registered.
  always_comb begin
    state_s    = state_r;
    win_s      = win_r;
    rem_s      = remaining_o;
    windows_s  = windows_o;
    done_s     = 1'b0;
    intr_set_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // stop_i beats a simultaneous start; a zero-length window is ignored.
        if (start_i && !stop_i && (window_i != WIN_ZERO)) begin
          state_s = ST_CLEAR;
          win_s   = window_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (stop_i) begin
          state_s = ST_IDLE;
          rem_s   = WIN_ZERO;
        end else begin
          state_s = ST_RUN;
          rem_s   = win_r;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_s = ST_IDLE;
          rem_s   = WIN_ZERO;
        end else if (remaining_o == WIN_ONE) begin
          // Last enabled cycle: freeze and report completion.
          state_s    = ST_HOLD;
          rem_s      = WIN_ZERO;
          done_s     = 1'b1;
          intr_set_s = 1'b1;
          windows_s  = windows_o + CNT_ONE;
        end else begin
          rem_s = remaining_o - WIN_ONE;
        end
      end
      ST_HOLD: begin
        if (stop_i) begin
          state_s = ST_IDLE;
        end else if (periodic_s) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
        rem_s = WIN_ZERO;
      end
      default: begin
        state_s = ST_IDLE;
        rem_s   = WIN_ZERO;
      end
    endcase

    // The config word follows the state being entered, so cfg_o is in step
    // with the state register.
    case (state_s)
      ST_CLEAR: cfg_s = CFG_SOFTRST;
      ST_RUN:   cfg_s = CFG_EN;
      default:  cfg_s = CFG_OFF;
    endcase

    busy_s = (state_s != ST_IDLE);

    if (intr_set_s) begin
      intr_s = 1'b1;
    end else if (intr_clr_i) begin
      intr_s = 1'b0;
    end else begin
      intr_s = intr_o;
    end
  end

  // State and output registers; reset clears the PMU enable asynchronously.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      win_r       <= WIN_ZERO;
      cfg_o       <= CFG_OFF;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      intr_o      <= 1'b0;
      remaining_o <= WIN_ZERO;
      windows_o   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      win_r       <= win_s;
      cfg_o       <= cfg_s;
      busy_o      <= busy_s;
      done_o      <= done_s;
      intr_o      <= intr_s;
      remaining_o <= rem_s;
      windows_o   <= windows_s;
    end
  end

endmodule

// File: tb/tb_pmu_window_seq.sv
// -----------------------------------------------------------------------------
// tb_pmu_window_seq
//
// Directed bench for pmu_window_seq (CNT_WIDTH = 2 so the window counter wraps
// quickly). The stimulus process queues the expected output vector for each
// cycle it drives. A monitor on the falling edge pops and compares the entries
// that fall due in that cycle.
// -----------------------------------------------------------------------------
module tb_pmu_window_seq;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [31:0] window_i = 32'd0;
  logic        periodic_i = 1'b0;
  logic        intr_clr_i = 1'b0;
  logic [31:0] cfg_o;
  logic        busy_o;
  logic        done_o;
  logic        intr_o;
  logic [31:0] remaining_o;
  logic [1:0]  windows_o;

  pmu_window_seq #(.REG_WIDTH(32), .WIN_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .window_i    (window_i),
    .periodic_i  (periodic_i),
    .intr_clr_i  (intr_clr_i),
    .cfg_o       (cfg_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .intr_o      (intr_o),
    .remaining_o (remaining_o),
    .windows_o   (windows_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [31:0] cfg;
    logic        busy;
    logic        done;
    logic        intr;
    logic [31:0] rem;
    logic [1:0]  win;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  string tag = "reset";
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  logic  finished = 1'b0;
  logic [1:0] ew = 2'd0;   // expected windows_o
  logic       ei = 1'b0;   // expected intr_o

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that falls due in this cycle.
  always @(negedge clk_i) begin
    exp_t  e;
    string t;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      t = tq.pop_front();
      n_checks++;
      if (e.cyc != cyc || cfg_o !== e.cfg || busy_o !== e.busy || done_o !== e.done ||
          intr_o !== e.intr || remaining_o !== e.rem || windows_o !== e.win) begin
        n_fail++;
        $display("FAIL %s cyc=%0d (due %0d): got cfg=%h busy=%b done=%b intr=%b rem=%0d win=%0d, expected cfg=%h busy=%b done=%b intr=%b rem=%0d win=%0d",
                 t, cyc, e.cyc, cfg_o, busy_o, done_o, intr_o, remaining_o, windows_o,
                 e.cfg, e.busy, e.done, e.intr, e.rem, e.win);
      end
    end
  end

  // Watchdog: the directed sequence must finish within a bounded time.
  initial begin
    #100000;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete, %0d expectations pending", q.size());
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else begin
      $display("watchdog idle");
    end
  end

  function automatic void push(input int c, input logic [31:0] cfg, input logic busy,
                               input logic done, input logic intr, input logic [31:0] rem,
                               input logic [1:0] win);
    exp_t e;
    e.cyc = c; e.cfg = cfg; e.busy = busy; e.done = done; e.intr = intr; e.rem = rem; e.win = win;
    q.push_back(e);
    tq.push_back(tag);
  endfunction

  // Called at a falling edge with inputs already set: queue the outputs that
  // must appear after the next rising edge, move on one cycle, then drop pulses.
  task automatic cyc_step(input logic [31:0] cfg, input logic busy, input logic done,
                          input logic intr, input logic [31:0] rem, input logic [1:0] win);
    push(cyc + 1, cfg, busy, done, intr, rem, win);
    @(negedge clk_i);
    start_i    = 1'b0;
    stop_i     = 1'b0;
    intr_clr_i = 1'b0;
  endtask

  // CLEAR followed by w RUN cycles; the caller handles the HOLD cycle.
  task automatic run_body(input int w);
    cyc_step(32'h2, 1'b1, 1'b0, ei, 32'd0, ew);
    for (int i = w; i >= 1; i--) cyc_step(32'h1, 1'b1, 1'b0, ei, 32'(i), ew);
    ew = ew + 2'd1;
    ei = 1'b1;
  endtask

  initial begin
    // Reset state, then idle after release.
    @(negedge clk_i);
    n_checks++;
    if (cfg_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0 || intr_o !== 1'b0 ||
        remaining_o !== 32'd0 || windows_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: cfg=%h busy=%b done=%b intr=%b rem=%0d win=%0d",
               cfg_o, busy_o, done_o, intr_o, remaining_o, windows_o);
    end
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0);
    rstn_i = 1'b1;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0);

    // W=5 single window; a start during RUN with another length is ignored.
    tag = "w5_window";
    start_i = 1'b1; window_i = 32'd5;
    cyc_step(32'h2, 1'b1, 1'b0, 1'b0, 32'd0, 2'd0);
    for (int i = 5; i >= 1; i--) begin
      if (i == 3) begin start_i = 1'b1; window_i = 32'd7; end
      cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'(i), 2'd0);
    end
    ew = 2'd1; ei = 1'b1;
    cyc_step(32'h0, 1'b1, 1'b1, 1'b1, 32'd0, 2'd1);
    cyc_step(32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd1);

    // Zero-length start is ignored.
    tag = "w0_ignored";
    start_i = 1'b1; window_i = 32'd0;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd1);
    cyc_step(32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd1);

    // Clear the interrupt; stop beats a simultaneous start in IDLE.
    tag = "intr_clear";
    intr_clr_i = 1'b1; ei = 1'b0;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd1);
    tag = "stop_beats_start";
    start_i = 1'b1; stop_i = 1'b1; window_i = 32'd4;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd1);
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd1);

    // W=10 aborted in the third RUN cycle.
    tag = "w10_stop";
    start_i = 1'b1; window_i = 32'd10;
    cyc_step(32'h2, 1'b1, 1'b0, 1'b0, 32'd0, 2'd1);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd10, 2'd1);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd9, 2'd1);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd8, 2'd1);
    stop_i = 1'b1;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd1);
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd1);

    // W=1: clear coincides with completion (set wins), then clear in HOLD.
    tag = "set_beats_clear";
    start_i = 1'b1; window_i = 32'd1;
    cyc_step(32'h2, 1'b1, 1'b0, 1'b0, 32'd0, 2'd1);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd1, 2'd1);
    intr_clr_i = 1'b1;
    cyc_step(32'h0, 1'b1, 1'b1, 1'b1, 32'd0, 2'd2);
    tag = "clear_after_set";
    intr_clr_i = 1'b1;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd2);
    ew = 2'd2; ei = 1'b0;

`ifdef PMU_WINDOW_SEQ_PERIODIC_EN
    // Periodic W=3: done every 5 cycles; counter goes 3,0,1,2 (wraps).
    tag = "periodic_w3";
    periodic_i = 1'b1; start_i = 1'b1; window_i = 32'd3;
    for (int k = 0; k < 4; k++) begin
      run_body(3);
      if (k == 3) periodic_i = 1'b0;
      cyc_step(32'h0, 1'b1, 1'b1, 1'b1, 32'd0, ew);
    end
    cyc_step(32'h0, 1'b0, 1'b0, 1'b1, 32'd0, ew);
`else
    // periodic_i has no effect without the feature; counter wraps 3 -> 0.
    tag = "periodic_ignored";
    periodic_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_i = 1'b1; window_i = 32'd2;
      run_body(2);
      cyc_step(32'h0, 1'b1, 1'b1, 1'b1, 32'd0, ew);
      cyc_step(32'h0, 1'b0, 1'b0, 1'b1, 32'd0, ew);
    end
    periodic_i = 1'b0;
`endif

    // Asynchronous reset in the middle of a W=100 window.
    tag = "async_reset";
    intr_clr_i = 1'b1; ei = 1'b0;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, ew);
    start_i = 1'b1; window_i = 32'd100;
    cyc_step(32'h2, 1'b1, 1'b0, 1'b0, 32'd0, ew);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd100, ew);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd99, ew);
    cyc_step(32'h1, 1'b1, 1'b0, 1'b0, 32'd98, ew);
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    push(cyc, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0);
    @(negedge clk_i);
    ew = 2'd0; ei = 1'b0;
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0);
    rstn_i = 1'b1;
    tag = "after_reset";
    cyc_step(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0);
    start_i = 1'b1; window_i = 32'd2;
    run_body(2);
    cyc_step(32'h0, 1'b1, 1'b1, 1'b1, 32'd0, 2'd1);
    cyc_step(32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd1);

    @(negedge clk_i);
    @(negedge clk_i);
    finished = 1'b1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d expectations never checked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
